// File: rtl/iommu_axi_sid_tagger.sv
// AXI4 stream-ID tagger: attaches stream_id/substream_id to every AW/AR beat
// and only lets the device-ID configuration change once all traffic has drained.

package lint_wrapper;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned UserWidth = 1;

  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [UserWidth-1:0]   user_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    user_t       user;
  } aw_chan_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    user_t       user;
  } ar_chan_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    user_t       user;
    logic [23:0] stream_id;
    logic        ss_id_valid;
    logic [19:0] substream_id;
  } aw_chan_iommu_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    user_t       user;
    logic [23:0] stream_id;
    logic        ss_id_valid;
    logic [19:0] substream_id;
  } ar_chan_iommu_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    aw_chan_iommu_t aw;
    logic           aw_valid;
    w_chan_t        w;
    logic           w_valid;
    logic           b_ready;
    ar_chan_iommu_t ar;
    logic           ar_valid;
    logic           r_ready;
  } req_iommu_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

// Two-entry slice: input-side full flag depends only on local state, so the
// device ready never sees the downstream ready combinationally.
module iommu_axi_sid_tagger_slice #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  output logic full_o,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);
  logic [1:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  T           mem_q [2];
  T           mem_d [2];
  logic       push, pop;

  assign full_o  = (cnt_q == 2'd2);
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = mem_q[rd_q];
  assign push    = push_i & ~full_o;
  assign pop     = valid_o & ready_i;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = data_i;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

module iommu_axi_sid_tagger #(
  parameter int unsigned MaxOutstanding = 16,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  lint_wrapper::req_t       dev_req_i,
  output lint_wrapper::resp_t      dev_resp_o,
  output lint_wrapper::req_iommu_t iommu_req_o,
  input  lint_wrapper::resp_t      iommu_resp_i,
  input  logic [23:0]              cfg_sid_i,
  input  logic                     cfg_ssidv_i,
  input  logic [19:0]              cfg_ssid_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  output logic [CntWidth-1:0]      aw_pending_o,
  output logic [CntWidth-1:0]      ar_pending_o,
  output logic                     idle_o
);
  import lint_wrapper::*;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [23:0]         sid_q, sid_d;
  logic                ssidv_q, ssidv_d;
  logic [19:0]         ssid_q, ssid_d;
  logic [CntWidth-1:0] aw_cnt_q, aw_cnt_d;
  logic [CntWidth-1:0] ar_cnt_q, ar_cnt_d;

  aw_chan_iommu_t aw_tagged, aw_out;
  ar_chan_iommu_t ar_tagged, ar_out;
  logic aw_full, aw_out_valid, ar_full, ar_out_valid;
  logic accept_en, drained, cfg_hs;
  logic dev_aw_ready, dev_ar_ready;
  logic aw_hs, ar_hs, b_hs, r_last_hs;

  assign drained     = (aw_cnt_q == '0) & (ar_cnt_q == '0) & ~aw_out_valid & ~ar_out_valid;
  assign cfg_ready_o = drained;
  assign cfg_hs      = cfg_valid_i & drained;

  assign dev_aw_ready = accept_en & (aw_cnt_q < CntWidth'(MaxOutstanding)) & ~aw_full;
  assign dev_ar_ready = accept_en & (ar_cnt_q < CntWidth'(MaxOutstanding)) & ~ar_full;
  assign aw_hs        = dev_req_i.aw_valid & dev_aw_ready;
  assign ar_hs        = dev_req_i.ar_valid & dev_ar_ready;
  assign b_hs         = iommu_resp_i.b_valid & dev_req_i.b_ready;
  assign r_last_hs    = iommu_resp_i.r_valid & dev_req_i.r_ready & iommu_resp_i.r.last;

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (cfg_valid_i && !cfg_ready_o) state_d = DRAIN;
      DRAIN:   if (cfg_hs || !cfg_valid_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs; a pending cfg request blocks captures so tags never race them
  always_comb begin
    accept_en = (state_q == RUN) & ~cfg_valid_i;
    idle_o    = drained & (state_q == RUN);
  end

  always_comb begin
    sid_d   = sid_q;
    ssidv_d = ssidv_q;
    ssid_d  = ssid_q;
    if (cfg_hs) begin
      sid_d   = cfg_sid_i;
      ssidv_d = cfg_ssidv_i;
      ssid_d  = cfg_ssid_i;
    end
  end

  always_comb begin
    aw_cnt_d = aw_cnt_q;
    if (aw_hs && !b_hs) begin
      aw_cnt_d = aw_cnt_q + CntWidth'(1);
    end else if (!aw_hs && b_hs && aw_cnt_q != '0) begin
      aw_cnt_d = aw_cnt_q - CntWidth'(1);
    end
  end

  always_comb begin
    ar_cnt_d = ar_cnt_q;
    if (ar_hs && !r_last_hs) begin
      ar_cnt_d = ar_cnt_q + CntWidth'(1);
    end else if (!ar_hs && r_last_hs && ar_cnt_q != '0) begin
      ar_cnt_d = ar_cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sid_q    <= '0;
      ssidv_q  <= 1'b0;
      ssid_q   <= '0;
      aw_cnt_q <= '0;
      ar_cnt_q <= '0;
    end else begin
      sid_q    <= sid_d;
      ssidv_q  <= ssidv_d;
      ssid_q   <= ssid_d;
      aw_cnt_q <= aw_cnt_d;
      ar_cnt_q <= ar_cnt_d;
    end
  end

  assign aw_pending_o = aw_cnt_q;
  assign ar_pending_o = ar_cnt_q;

  always_comb begin
    aw_tagged              = '0;
    aw_tagged.id           = dev_req_i.aw.id;
    aw_tagged.addr         = dev_req_i.aw.addr;
    aw_tagged.len          = dev_req_i.aw.len;
    aw_tagged.size         = dev_req_i.aw.size;
    aw_tagged.burst        = dev_req_i.aw.burst;
    aw_tagged.lock         = dev_req_i.aw.lock;
    aw_tagged.cache        = dev_req_i.aw.cache;
    aw_tagged.prot         = dev_req_i.aw.prot;
    aw_tagged.qos          = dev_req_i.aw.qos;
    aw_tagged.region       = dev_req_i.aw.region;
    aw_tagged.atop         = dev_req_i.aw.atop;
    aw_tagged.user         = dev_req_i.aw.user;
    aw_tagged.stream_id    = sid_q;
    aw_tagged.ss_id_valid  = ssidv_q;
    aw_tagged.substream_id = ssid_q;
  end

  always_comb begin
    ar_tagged              = '0;
    ar_tagged.id           = dev_req_i.ar.id;
    ar_tagged.addr         = dev_req_i.ar.addr;
    ar_tagged.len          = dev_req_i.ar.len;
    ar_tagged.size         = dev_req_i.ar.size;
    ar_tagged.burst        = dev_req_i.ar.burst;
    ar_tagged.lock         = dev_req_i.ar.lock;
    ar_tagged.cache        = dev_req_i.ar.cache;
    ar_tagged.prot         = dev_req_i.ar.prot;
    ar_tagged.qos          = dev_req_i.ar.qos;
    ar_tagged.region       = dev_req_i.ar.region;
    ar_tagged.user         = dev_req_i.ar.user;
    ar_tagged.stream_id    = sid_q;
    ar_tagged.ss_id_valid  = ssidv_q;
    ar_tagged.substream_id = ssid_q;
  end

  iommu_axi_sid_tagger_slice #(.T(aw_chan_iommu_t)) i_aw_slice (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (aw_hs),
    .data_i  (aw_tagged),
    .full_o  (aw_full),
    .valid_o (aw_out_valid),
    .ready_i (iommu_resp_i.aw_ready),
    .data_o  (aw_out)
  );

  iommu_axi_sid_tagger_slice #(.T(ar_chan_iommu_t)) i_ar_slice (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ar_hs),
    .data_i  (ar_tagged),
    .full_o  (ar_full),
    .valid_o (ar_out_valid),
    .ready_i (iommu_resp_i.ar_ready),
    .data_o  (ar_out)
  );

  always_comb begin
    iommu_req_o          = '0;
    iommu_req_o.aw       = aw_out;
    iommu_req_o.aw_valid = aw_out_valid;
    iommu_req_o.w        = dev_req_i.w;
    iommu_req_o.w_valid  = dev_req_i.w_valid;
    iommu_req_o.b_ready  = dev_req_i.b_ready;
    iommu_req_o.ar       = ar_out;
    iommu_req_o.ar_valid = ar_out_valid;
    iommu_req_o.r_ready  = dev_req_i.r_ready;
  end

  always_comb begin
    dev_resp_o          = '0;
    dev_resp_o.aw_ready = dev_aw_ready;
    dev_resp_o.ar_ready = dev_ar_ready;
    dev_resp_o.w_ready  = iommu_resp_i.w_ready;
    dev_resp_o.b_valid  = iommu_resp_i.b_valid;
    dev_resp_o.b        = iommu_resp_i.b;
    dev_resp_o.r_valid  = iommu_resp_i.r_valid;
    dev_resp_o.r        = iommu_resp_i.r;
  end

  // Responses without an open transaction are protocol violations
  assert property (@(posedge clk_i) disable iff (rst_i) !(b_hs && aw_cnt_q == '0));
  assert property (@(posedge clk_i) disable iff (rst_i) !(r_last_hs && ar_cnt_q == '0));
endmodule

// File: tb/tb_iommu_axi_sid_tagger.sv
// Directed bench for iommu_axi_sid_tagger: vector table plus multi-cycle sequences.

module tb_iommu_axi_sid_tagger;
  import lint_wrapper::*;

  logic       clk = 1'b0;
  logic       rst;
  req_t       dev_req;
  resp_t      dev_resp;
  req_iommu_t iommu_req;
  resp_t      iommu_resp;
  logic [23:0] cfg_sid;
  logic        cfg_ssidv;
  logic [19:0] cfg_ssid;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [4:0]  aw_pending;
  logic [4:0]  ar_pending;
  logic        idle;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  iommu_axi_sid_tagger dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .dev_req_i    (dev_req),
    .dev_resp_o   (dev_resp),
    .iommu_req_o  (iommu_req),
    .iommu_resp_i (iommu_resp),
    .cfg_sid_i    (cfg_sid),
    .cfg_ssidv_i  (cfg_ssidv),
    .cfg_ssid_i   (cfg_ssid),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .aw_pending_o (aw_pending),
    .ar_pending_o (ar_pending),
    .idle_o       (idle)
  );

  typedef struct {
    logic awv, arv, iawr, iarr, bv, rv, rl, cfgv;
    logic e_awr, e_arr, e_iawv, e_iarv;
    logic [4:0] e_awp, e_arp;
    logic e_cfgr, e_idle;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    dev_req            = '0;
    dev_req.b_ready    = 1'b1;
    dev_req.r_ready    = 1'b1;
    iommu_resp         = '0;
    iommu_resp.aw_ready = 1'b1;
    iommu_resp.ar_ready = 1'b1;
    iommu_resp.w_ready  = 1'b1;
    cfg_valid = 1'b0;
    cfg_sid   = '0;
    cfg_ssidv = 1'b0;
    cfg_ssid  = '0;
  endtask

  initial begin
    int acc, sent, got, gaps;
    logic [63:0] base;

    //             awv arv iawr iarr bv rv rl cfgv | awr arr iawv iarv awp arp cfgr idle
    vecs[0]  = '{0, 0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 5'd0, 5'd0, 1, 1};
    vecs[1]  = '{1, 0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 5'd0, 5'd0, 1, 1};
    vecs[2]  = '{0, 0, 1, 1, 0, 0, 0, 0,  1, 1, 1, 0, 5'd1, 5'd0, 0, 0};
    vecs[3]  = '{0, 0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 5'd1, 5'd0, 0, 0};
    vecs[4]  = '{0, 0, 1, 1, 1, 0, 0, 0,  1, 1, 0, 0, 5'd1, 5'd0, 0, 0};
    vecs[5]  = '{0, 0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 5'd0, 5'd0, 1, 1};
    vecs[6]  = '{0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 5'd0, 5'd0, 1, 1};
    vecs[7]  = '{0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 1, 5'd0, 5'd1, 0, 0};
    vecs[8]  = '{0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 5'd0, 5'd2, 0, 0};
    vecs[9]  = '{0, 0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 1, 5'd0, 5'd2, 0, 0};
    vecs[10] = '{0, 0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 1, 5'd0, 5'd2, 0, 0};
    vecs[11] = '{0, 0, 1, 1, 0, 1, 0, 0,  1, 1, 0, 0, 5'd0, 5'd2, 0, 0};
    vecs[12] = '{0, 0, 1, 1, 0, 1, 1, 0,  1, 1, 0, 0, 5'd0, 5'd2, 0, 0};
    vecs[13] = '{0, 1, 1, 1, 0, 1, 1, 0,  1, 1, 0, 0, 5'd0, 5'd1, 0, 0};
    vecs[14] = '{0, 0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 1, 5'd0, 5'd1, 0, 0};
    vecs[15] = '{0, 0, 1, 1, 0, 1, 1, 0,  1, 1, 0, 0, 5'd0, 5'd1, 0, 0};
    vecs[16] = '{0, 0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 5'd0, 5'd0, 1, 1};
    vecs[17] = '{0, 0, 1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 5'd0, 5'd0, 1, 1};
    vecs[18] = '{0, 0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 5'd0, 5'd0, 1, 1};

    rst = 1'b1;
    clr();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table: inputs applied after a falling edge, outputs checked before the next rising edge
    for (int i = 0; i < 19; i++) begin
      dev_req.aw_valid    = vecs[i].awv;
      dev_req.aw.addr     = 64'h1000;
      dev_req.aw.id       = 4'd3;
      dev_req.ar_valid    = vecs[i].arv;
      dev_req.ar.addr     = 64'h3000;
      iommu_resp.aw_ready = vecs[i].iawr;
      iommu_resp.ar_ready = vecs[i].iarr;
      iommu_resp.b_valid  = vecs[i].bv;
      iommu_resp.r_valid  = vecs[i].rv;
      iommu_resp.r.last   = vecs[i].rl;
      cfg_valid           = vecs[i].cfgv;
      #1;
      chk($sformatf("v%0d.aw_ready", i), 64'(dev_resp.aw_ready), 64'(vecs[i].e_awr));
      chk($sformatf("v%0d.ar_ready", i), 64'(dev_resp.ar_ready), 64'(vecs[i].e_arr));
      chk($sformatf("v%0d.iommu_aw_valid", i), 64'(iommu_req.aw_valid), 64'(vecs[i].e_iawv));
      chk($sformatf("v%0d.iommu_ar_valid", i), 64'(iommu_req.ar_valid), 64'(vecs[i].e_iarv));
      chk($sformatf("v%0d.aw_pending", i), 64'(aw_pending), 64'(vecs[i].e_awp));
      chk($sformatf("v%0d.ar_pending", i), 64'(ar_pending), 64'(vecs[i].e_arp));
      chk($sformatf("v%0d.cfg_ready", i), 64'(cfg_ready), 64'(vecs[i].e_cfgr));
      chk($sformatf("v%0d.idle", i), 64'(idle), 64'(vecs[i].e_idle));
      @(negedge clk);
    end

    // AW with reset tags: payload and zero tags reach the IOMMU one cycle later
    clr();
    iommu_resp.aw_ready = 1'b0;
    dev_req.aw_valid = 1'b1;
    dev_req.aw.addr  = 64'h1000;
    dev_req.aw.id    = 4'd3;
    @(negedge clk);
    dev_req.aw_valid = 1'b0;
    #1;
    chk("aw0.valid", 64'(iommu_req.aw_valid), 64'd1);
    chk("aw0.addr", iommu_req.aw.addr, 64'h1000);
    chk("aw0.id", 64'(iommu_req.aw.id), 64'd3);
    chk("aw0.sid", 64'(iommu_req.aw.stream_id), 64'd0);
    chk("aw0.ssidv", 64'(iommu_req.aw.ss_id_valid), 64'd0);
    chk("aw0.pending", 64'(aw_pending), 64'd1);
    iommu_resp.aw_ready = 1'b1;
    @(negedge clk);
    iommu_resp.b_valid = 1'b1;
    @(negedge clk);
    iommu_resp.b_valid = 1'b0;
    #1;
    chk("aw0.pending_after_b", 64'(aw_pending), 64'd0);

    // Config while idle, then an AR carries the new tags
    @(negedge clk);
    clr();
    cfg_sid   = 24'h00ABCD;
    cfg_ssidv = 1'b1;
    cfg_ssid  = 20'h12345;
    cfg_valid = 1'b1;
    #1;
    chk("cfg.ready_idle", 64'(cfg_ready), 64'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    iommu_resp.ar_ready = 1'b0;
    dev_req.ar_valid = 1'b1;
    dev_req.ar.addr  = 64'h2000;
    #1;
    chk("cfg.ar_ready_after", 64'(dev_resp.ar_ready), 64'd1);
    @(negedge clk);
    dev_req.ar_valid = 1'b0;
    #1;
    chk("ar1.addr", iommu_req.ar.addr, 64'h2000);
    chk("ar1.sid", 64'(iommu_req.ar.stream_id), 64'h00ABCD);
    chk("ar1.ssidv", 64'(iommu_req.ar.ss_id_valid), 64'd1);
    chk("ar1.ssid", 64'(iommu_req.ar.substream_id), 64'h12345);
    iommu_resp.ar_ready = 1'b1;
    @(negedge clk);
    iommu_resp.r_valid = 1'b1;
    iommu_resp.r.last  = 1'b1;
    @(negedge clk);
    iommu_resp.r_valid = 1'b0;
    #1;
    chk("ar1.pending_after_r", 64'(ar_pending), 64'd0);

    // Drain: 3 open reads (len 3) hold off a config change until 12 R beats
    @(negedge clk);
    clr();
    dev_req.ar_valid = 1'b1;
    dev_req.ar.len   = 8'd3;
    repeat (3) @(negedge clk);
    dev_req.ar_valid = 1'b0;
    #1;
    chk("drain.ar_pending3", 64'(ar_pending), 64'd3);
    cfg_sid   = 24'h000077;
    cfg_ssidv = 1'b0;
    cfg_ssid  = 20'h5;
    cfg_valid = 1'b1;
    #1;
    chk("drain.cfg_ready0", 64'(cfg_ready), 64'd0);
    chk("drain.ar_ready0", 64'(dev_resp.ar_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("drain.idle0", 64'(idle), 64'd0);
    chk("drain.ar_ready_in_drain", 64'(dev_resp.ar_ready), 64'd0);
    @(negedge clk);
    iommu_resp.r_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      iommu_resp.r.last = ((i % 4) == 3);
      @(negedge clk);
    end
    iommu_resp.r_valid = 1'b0;
    iommu_resp.r.last  = 1'b0;
    #1;
    chk("drain.ar_pending0", 64'(ar_pending), 64'd0);
    chk("drain.cfg_ready1", 64'(cfg_ready), 64'd1);
    chk("drain.idle_still_drain", 64'(idle), 64'd0);
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    chk("drain.idle_run", 64'(idle), 64'd1);
    chk("drain.ar_ready_run", 64'(dev_resp.ar_ready), 64'd1);

    // 16 AWs with no B: limit reached, one B reopens, simultaneous AW+B holds count
    @(negedge clk);
    clr();
    acc = 0;
    for (int c = 0; c < 40 && acc < 16; c++) begin
      dev_req.aw_valid = 1'b1;
      #1;
      if (dev_resp.aw_ready) acc++;
      @(negedge clk);
    end
    dev_req.aw_valid = 1'b0;
    #1;
    chk("lim.accepted", 64'(acc), 64'd16);
    chk("lim.aw_pending16", 64'(aw_pending), 64'd16);
    chk("lim.aw_ready0", 64'(dev_resp.aw_ready), 64'd0);
    @(negedge clk);
    iommu_resp.b_valid = 1'b1;
    @(negedge clk);
    iommu_resp.b_valid = 1'b0;
    #1;
    chk("lim.aw_pending15", 64'(aw_pending), 64'd15);
    chk("lim.aw_ready1", 64'(dev_resp.aw_ready), 64'd1);
    @(negedge clk);
    dev_req.aw_valid   = 1'b1;
    iommu_resp.b_valid = 1'b1;
    @(negedge clk);
    dev_req.aw_valid   = 1'b0;
    iommu_resp.b_valid = 1'b0;
    #1;
    chk("lim.same_cycle", 64'(aw_pending), 64'd15);
    @(negedge clk);
    iommu_resp.b_valid = 1'b1;
    repeat (15) @(negedge clk);
    iommu_resp.b_valid = 1'b0;
    #1;
    chk("lim.aw_pending0", 64'(aw_pending), 64'd0);

    // Backpressure: IOMMU stalls 5 cycles, slice holds exactly 2, then drains in order
    @(negedge clk);
    clr();
    base = 64'h8000;
    iommu_resp.aw_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 5; c++) begin
      dev_req.aw_valid = 1'b1;
      dev_req.aw.addr  = base + 64'(sent);
      #1;
      if (dev_resp.aw_ready) sent++;
      @(negedge clk);
    end
    #1;
    chk("bp.held", 64'(sent), 64'd2);
    chk("bp.aw_ready0", 64'(dev_resp.aw_ready), 64'd0);
    chk("bp.head_addr", iommu_req.aw.addr, base);
    chk("bp.head_sid", 64'(iommu_req.aw.stream_id), 64'h000077);
    chk("bp.aw_pending", 64'(aw_pending), 64'd2);
    @(negedge clk);
    iommu_resp.aw_ready = 1'b1;
    got  = 0;
    gaps = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      dev_req.aw_valid = (sent < 6);
      dev_req.aw.addr  = base + 64'(sent);
      #1;
      if (iommu_req.aw_valid) begin
        chk($sformatf("bp.order%0d", got), iommu_req.aw.addr, base + 64'(got));
        got++;
      end else begin
        gaps++;
      end
      if (dev_req.aw_valid && dev_resp.aw_ready) sent++;
      @(negedge clk);
    end
    dev_req.aw_valid = 1'b0;
    chk("bp.drained_beats", 64'(got), 64'd6);
    chk("bp.gaps", 64'(gaps), 64'd0);

    // Asynchronous reset with 2 open reads: outputs clear before any clock edge
    clr();
    iommu_resp.ar_ready = 1'b0;
    dev_req.ar_valid = 1'b1;
    repeat (2) @(negedge clk);
    dev_req.ar_valid = 1'b0;
    #1;
    chk("rst.ar_pending2", 64'(ar_pending), 64'd2);
    chk("rst.ar_valid_before", 64'(iommu_req.ar_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst.ar_valid", 64'(iommu_req.ar_valid), 64'd0);
    chk("rst.aw_valid", 64'(iommu_req.aw_valid), 64'd0);
    chk("rst.ar_pending", 64'(ar_pending), 64'd0);
    chk("rst.aw_pending", 64'(aw_pending), 64'd0);
    chk("rst.cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst.idle", 64'(idle), 64'd1);
    chk("rst.ar_ready", 64'(dev_resp.ar_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
